// File: rtl/smac_frame.sv
// Framed signed multiply-accumulate: four-stage pipeline (register, multiply, accumulate, convert)
// emitting one rounded/shifted/saturated result with overflow and saturation flags per frame.
module smac_frame #(
   parameter int AWIDTH   = 8,
   parameter int BWIDTH   = 8,
   parameter int ACCWIDTH = AWIDTH + BWIDTH + 8,
   parameter int SHIFT    = 0,
   parameter int OWIDTH   = ACCWIDTH,
   parameter int ACC_SAT  = 1,
   parameter int OUT_SAT  = 1
) (
   input  logic                     clk,
   input  logic                     sclr_n,
   input  logic                     clken,
   input  logic                     in_valid,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic signed [AWIDTH-1:0] da,
   input  logic signed [BWIDTH-1:0] db,
   output logic                     out_valid,
   output logic signed [OWIDTH-1:0] out,
   output logic                     out_ovf,
   output logic                     out_sat
);

   localparam int PWIDTH = AWIDTH + BWIDTH;
   localparam int TWIDTH = ACCWIDTH - OWIDTH + 2;
   localparam logic [ACCWIDTH:0] ONE = 1;
   localparam logic signed [ACCWIDTH:0] RND = (ONE << SHIFT) >> 1;
   localparam logic signed [ACCWIDTH-1:0] ACC_MAX = {1'b0, {(ACCWIDTH-1){1'b1}}};
   localparam logic signed [ACCWIDTH-1:0] ACC_MIN = {1'b1, {(ACCWIDTH-1){1'b0}}};
   localparam logic signed [OWIDTH-1:0] OUT_MAX = {1'b0, {(OWIDTH-1){1'b1}}};
   localparam logic signed [OWIDTH-1:0] OUT_MIN = {1'b1, {(OWIDTH-1){1'b0}}};

   logic                       s1_valid, s1_first, s1_last;
   logic signed [AWIDTH-1:0]   s1_a;
   logic signed [BWIDTH-1:0]   s1_b;
   logic                       s2_valid, s2_first, s2_last;
   logic signed [PWIDTH-1:0]   s2_p;
   logic signed [ACCWIDTH-1:0] acc;
   logic                       ovf;
   logic                       s3_last;

   logic signed [ACCWIDTH-1:0] pext, sum, acc_next;
   logic                       add_ovf, ovf_next;
   logic signed [ACCWIDTH:0]   wide, shifted;
   logic [TWIDTH-1:0]          top;
   logic                       fits;
   logic signed [OWIDTH-1:0]   conv;

   // Accumulator next state: a frame start reloads, otherwise add with optional clamping.
   always_comb begin
      pext     = ACCWIDTH'(s2_p);
      sum      = acc + pext;
      add_ovf  = (acc[ACCWIDTH-1] == pext[ACCWIDTH-1]) && (sum[ACCWIDTH-1] != acc[ACCWIDTH-1]);
      acc_next = acc;
      ovf_next = ovf;
      if (s2_valid) begin
         if (s2_first) begin
            acc_next = pext;
            ovf_next = 1'b0;
         end else begin
            ovf_next = ovf | add_ovf;
            if (add_ovf && (ACC_SAT != 0))
               acc_next = acc[ACCWIDTH-1] ? ACC_MIN : ACC_MAX;
            else
               acc_next = sum;
         end
      end
   end

   // Output conversion is one bit wider so the rounding constant cannot wrap the sum.
   always_comb begin
      wide    = (ACCWIDTH+1)'(acc) + RND;
      shifted = wide >>> SHIFT;
      top     = shifted[ACCWIDTH:OWIDTH-1];
      fits    = (&top) || !(|top);
      conv    = shifted[OWIDTH-1:0];
      if (!fits && (OUT_SAT != 0))
         conv = shifted[ACCWIDTH] ? OUT_MIN : OUT_MAX;
   end

   // Frame markers are qualified by in_valid at entry so later stages only see real samples.
   always_ff @(posedge clk) begin
      if (!sclr_n) begin
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s2_valid  <= 1'b0;
         s2_first  <= 1'b0;
         s2_last   <= 1'b0;
         s2_p      <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
         s3_last   <= 1'b0;
         out_valid <= 1'b0;
         out       <= '0;
         out_ovf   <= 1'b0;
         out_sat   <= 1'b0;
      end else if (clken) begin
         s1_valid  <= in_valid;
         s1_first  <= in_valid & in_first;
         s1_last   <= in_valid & in_last;
         s1_a      <= da;
         s1_b      <= db;
         s2_valid  <= s1_valid;
         s2_first  <= s1_first;
         s2_last   <= s1_last;
         s2_p      <= PWIDTH'(s1_a) * PWIDTH'(s1_b);
         acc       <= acc_next;
         ovf       <= ovf_next;
         s3_last   <= s2_valid & s2_last;
         out_valid <= s3_last;
         if (s3_last) begin
            out     <= conv;
            out_ovf <= ovf;
            out_sat <= !fits;
         end
      end
   end

endmodule

// File: tb/tb_smac_frame.sv
// Directed bench for smac_frame: four parameterisations share one stimulus stream and
// each scenario task checks the instances whose behaviour it exercises.
module tb_smac_frame;

   logic clk, sclr_n, clken, in_valid, in_first, in_last;
   logic signed [7:0] da, db;

   logic ov0, ovf0, sat0;
   logic signed [19:0] out0;
   logic ov1, ovf1, sat1;
   logic signed [15:0] out1;
   logic ov2, ovf2, sat2;
   logic signed [15:0] out2;
   logic ov3, ovf3, sat3;
   logic signed [7:0] out3;

   int tests_run = 0;
   int tests_failed = 0;

   // Default configuration: 20-bit accumulator, no shift.
   smac_frame #(.AWIDTH(8), .BWIDTH(8), .ACCWIDTH(20)) dut0 (
      .clk(clk), .sclr_n(sclr_n), .clken(clken), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .da(da), .db(db), .out_valid(ov0), .out(out0), .out_ovf(ovf0), .out_sat(sat0));

   // Narrow accumulator that clamps.
   smac_frame #(.AWIDTH(8), .BWIDTH(8), .ACCWIDTH(16), .ACC_SAT(1)) dut1 (
      .clk(clk), .sclr_n(sclr_n), .clken(clken), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .da(da), .db(db), .out_valid(ov1), .out(out1), .out_ovf(ovf1), .out_sat(sat1));

   // Narrow accumulator that wraps.
   smac_frame #(.AWIDTH(8), .BWIDTH(8), .ACCWIDTH(16), .ACC_SAT(0)) dut2 (
      .clk(clk), .sclr_n(sclr_n), .clken(clken), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .da(da), .db(db), .out_valid(ov2), .out(out2), .out_ovf(ovf2), .out_sat(sat2));

   // Rounded, shifted by 4 and saturated to 8 bits.
   smac_frame #(.AWIDTH(8), .BWIDTH(8), .ACCWIDTH(20), .SHIFT(4), .OWIDTH(8), .OUT_SAT(1)) dut3 (
      .clk(clk), .sclr_n(sclr_n), .clken(clken), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .da(da), .db(db), .out_valid(ov3), .out(out3), .out_ovf(ovf3), .out_sat(sat3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge and stay for one full cycle.
   task automatic applyStimulus(input logic v, input logic f, input logic l, input int a, input int b);
      in_valid = v;
      in_first = f;
      in_last  = l;
      da       = 8'(a);
      db       = 8'(b);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      sclr_n = 1'b0;
      clken  = 1'b1;
      idle(3);
      tests_run++; if (ov0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %0b expected 0", ov0); end
      tests_run++; if (out0 !== 0) begin tests_failed++; $display("[TB] FAIL reset_out: got %0d expected 0", out0); end
      tests_run++; if ({ovf0, sat0} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 00", {ovf0, sat0}); end
      sclr_n = 1'b1;
      idle(1);
   endtask

   task automatic test_frame();
      applyStimulus(1, 1, 0, 3, 4);
      applyStimulus(1, 0, 0, -2, 5);
      applyStimulus(1, 0, 0, 7, -1);
      applyStimulus(1, 0, 1, -8, -8);
      idle(2);
      tests_run++; if (ov0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_early: got %0b expected 0", ov0); end
      idle(1);
      tests_run++; if (ov0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL frame_valid: got %0b expected 1", ov0); end
      tests_run++; if (out0 !== 59) begin tests_failed++; $display("[TB] FAIL frame_out: got %0d expected 59", out0); end
      tests_run++; if ({ovf0, sat0} !== 2'b00) begin tests_failed++; $display("[TB] FAIL frame_flags: got %b expected 00", {ovf0, sat0}); end
      tests_run++; if (out3 !== 4) begin tests_failed++; $display("[TB] FAIL frame_shift_out: got %0d expected 4", out3); end
      idle(1);
      tests_run++; if (ov0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_pulse_end: got %0b expected 0", ov0); end
      tests_run++; if (out0 !== 59) begin tests_failed++; $display("[TB] FAIL frame_hold: got %0d expected 59", out0); end
   endtask

   task automatic test_back_to_back();
      applyStimulus(1, 1, 1, -128, -128);
      applyStimulus(1, 1, 1, 3, 4);
      idle(2);
      tests_run++; if (ov0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid1: got %0b expected 1", ov0); end
      tests_run++; if (out0 !== 16384) begin tests_failed++; $display("[TB] FAIL b2b_out1: got %0d expected 16384", out0); end
      tests_run++; if ({ovf0, sat0} !== 2'b00) begin tests_failed++; $display("[TB] FAIL b2b_flags1: got %b expected 00", {ovf0, sat0}); end
      tests_run++; if (out3 !== 127) begin tests_failed++; $display("[TB] FAIL b2b_shift_out1: got %0d expected 127", out3); end
      tests_run++; if (sat3 !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_shift_sat1: got %0b expected 1", sat3); end
      idle(1);
      tests_run++; if (ov0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid2: got %0b expected 1", ov0); end
      tests_run++; if (out0 !== 12) begin tests_failed++; $display("[TB] FAIL b2b_out2: got %0d expected 12", out0); end
      tests_run++; if (out3 !== 1) begin tests_failed++; $display("[TB] FAIL b2b_shift_out2: got %0d expected 1", out3); end
      tests_run++; if (sat3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_shift_sat2: got %0b expected 0", sat3); end
      idle(1);
      tests_run++; if (ov0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_end: got %0b expected 0", ov0); end
   endtask

   task automatic test_shift_round();
      applyStimulus(1, 1, 1, -4, 6);
      applyStimulus(1, 1, 1, 50, 60);
      applyStimulus(1, 1, 1, 2, 4);
      applyStimulus(1, 1, 1, -2, 4);
      tests_run++; if (ov3 !== 1'b1) begin tests_failed++; $display("[TB] FAIL shift_valid: got %0b expected 1", ov3); end
      tests_run++; if (out3 !== -1) begin tests_failed++; $display("[TB] FAIL shift_neg24: got %0d expected -1", out3); end
      tests_run++; if (sat3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL shift_neg24_sat: got %0b expected 0", sat3); end
      idle(1);
      tests_run++; if (out3 !== 127) begin tests_failed++; $display("[TB] FAIL shift_3000: got %0d expected 127", out3); end
      tests_run++; if (sat3 !== 1'b1) begin tests_failed++; $display("[TB] FAIL shift_3000_sat: got %0b expected 1", sat3); end
      idle(1);
      tests_run++; if (out3 !== 1) begin tests_failed++; $display("[TB] FAIL shift_half_pos: got %0d expected 1", out3); end
      idle(1);
      tests_run++; if (out3 !== 0) begin tests_failed++; $display("[TB] FAIL shift_half_neg: got %0d expected 0", out3); end
      tests_run++; if (sat3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL shift_half_neg_sat: got %0b expected 0", sat3); end
      idle(1);
   endtask

   task automatic test_acc_overflow();
      applyStimulus(1, 1, 0, -128, -128);
      applyStimulus(1, 0, 0, -128, -128);
      applyStimulus(1, 0, 1, -128, -128);
      idle(3);
      tests_run++; if (ov1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_valid: got %0b expected 1", ov1); end
      tests_run++; if (out1 !== 32767) begin tests_failed++; $display("[TB] FAIL ovf_clamp_out: got %0d expected 32767", out1); end
      tests_run++; if (ovf1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_clamp_flag: got %0b expected 1", ovf1); end
      tests_run++; if (out2 !== -16384) begin tests_failed++; $display("[TB] FAIL ovf_wrap_out: got %0d expected -16384", out2); end
      tests_run++; if (ovf2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_wrap_flag: got %0b expected 1", ovf2); end
      tests_run++; if (out0 !== 49152) begin tests_failed++; $display("[TB] FAIL ovf_wide_out: got %0d expected 49152", out0); end
      tests_run++; if (ovf0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_wide_flag: got %0b expected 0", ovf0); end
      idle(1);
   endtask

   task automatic test_sync_reset();
      logic seen;
      seen = 1'b0;
      applyStimulus(1, 1, 0, 3, 4);
      applyStimulus(1, 0, 1, 5, 5);
      sclr_n = 1'b0;
      idle(1);
      sclr_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idle(1);
         if (ov0 || ov1 || ov3) seen = 1'b1;
      end
      tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_no_valid: got %0b expected 0", seen); end
      tests_run++; if (out0 !== 0) begin tests_failed++; $display("[TB] FAIL rst_out: got %0d expected 0", out0); end
      tests_run++; if (ovf1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_ovf: got %0b expected 0", ovf1); end
      tests_run++; if (sat3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_sat: got %0b expected 0", sat3); end
      applyStimulus(1, 1, 0, 2, 3);
      applyStimulus(1, 0, 1, 4, 5);
      idle(3);
      tests_run++; if (ov0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_next_valid: got %0b expected 1", ov0); end
      tests_run++; if (out0 !== 26) begin tests_failed++; $display("[TB] FAIL rst_next_out: got %0d expected 26", out0); end
      idle(1);
   endtask

   task automatic test_restart();
      applyStimulus(1, 1, 0, 10, 10);
      applyStimulus(1, 0, 0, 1, 1);
      applyStimulus(1, 1, 0, 2, 3);
      applyStimulus(1, 0, 1, 1, 1);
      idle(3);
      tests_run++; if (ov0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_valid: got %0b expected 1", ov0); end
      tests_run++; if (out0 !== 7) begin tests_failed++; $display("[TB] FAIL restart_out: got %0d expected 7", out0); end
      idle(1);
   endtask

   task automatic test_clken();
      applyStimulus(1, 1, 0, 3, 4);
      applyStimulus(1, 0, 0, -2, 5);
      // Garbage samples while frozen must never be captured.
      clken = 1'b0;
      in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; da = 8'sd100; db = 8'sd100;
      repeat (3) @(negedge clk);
      clken = 1'b1;
      applyStimulus(1, 0, 0, 7, -1);
      applyStimulus(1, 0, 1, -8, -8);
      idle(2);
      tests_run++; if (ov0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL clken_early: got %0b expected 0", ov0); end
      idle(1);
      tests_run++; if (ov0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL clken_valid: got %0b expected 1", ov0); end
      tests_run++; if (out0 !== 59) begin tests_failed++; $display("[TB] FAIL clken_out: got %0d expected 59", out0); end
      clken = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++; if (ov0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL clken_pulse_held: got %0b expected 1", ov0); end
      tests_run++; if (out0 !== 59) begin tests_failed++; $display("[TB] FAIL clken_out_held: got %0d expected 59", out0); end
      clken = 1'b1;
      idle(1);
      tests_run++; if (ov0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL clken_pulse_end: got %0b expected 0", ov0); end
   endtask

   initial begin
      sclr_n = 1'b0; clken = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      da = '0; db = '0;
      @(negedge clk);
      test_reset();
      test_frame();
      test_back_to_back();
      test_shift_round();
      test_acc_overflow();
      test_sync_reset();
      test_restart();
      test_clken();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
